// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame levels and parity-type encodings.
// Used by both the transmitter and the receiver path.
package uart_pkg;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t ST_IDLE   = 3'd0;
    localparam tx_state_t ST_START  = 3'd1;
    localparam tx_state_t ST_DATA   = 3'd2;
    localparam tx_state_t ST_PARITY = 3'd3;
    localparam tx_state_t ST_STOP   = 3'd4;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Request/line bundle between a byte source and uart_tx.
// master = byte source, slave = transmitter.
interface uart_tx_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      DATA_VALID;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      TX_OUT;
    logic                      busy;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
        input  TX_OUT, busy
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
        output TX_OUT, busy
    );
endinterface

// File: rtl/uart_parity_calc.sv
// Combinational parity generator; odd type inverts the data XOR.
// Shared with the receiver's parity checker.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);
    assign par_bit = (^data) ^ (par_typ == PAR_ODD);
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_WIDTH bits LSB first, optional parity, stop; prescale clk per bit.
// Define UART_TX_TWO_STOP_EN to send two stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave tx_if
);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_t                 state;
    logic [PRESCALE_WIDTH-1:0] cnt;
    logic [PRESCALE_WIDTH-1:0] pre_q;
    logic [IDX_W-1:0]          bit_idx;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [DATA_WIDTH-1:0]     sh_q;
    logic                      par_en_q;
    logic                      par_typ_q;
    logic                      par_bit;
    logic                      tx_q;
    logic                      busy_q;
    logic                      bit_end;
`ifdef UART_TX_TWO_STOP_EN
    logic                      stop_second;
`endif

    uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
        .data    (data_q),
        .par_typ (par_typ_q),
        .par_bit (par_bit)
    );

    // pre_q is never 0 (prescale 0 latched as 1), so the subtraction cannot wrap
    assign bit_end      = (cnt == pre_q - 1'b1);
    assign tx_if.TX_OUT = tx_q;
    assign tx_if.busy   = busy_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pre_q     <= PRESCALE_WIDTH'(1);
            bit_idx   <= '0;
            data_q    <= '0;
            sh_q      <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop_second <= 1'b0;
`endif
        end else if (state == ST_IDLE) begin
            tx_q   <= IDLE_LEVEL;
            busy_q <= 1'b0;
            cnt    <= '0;
            if (tx_if.DATA_VALID) begin
                data_q    <= tx_if.P_DATA;
                sh_q      <= tx_if.P_DATA;
                par_en_q  <= tx_if.PAR_EN;
                par_typ_q <= tx_if.PAR_TYP;
                pre_q     <= (tx_if.prescale == '0) ? PRESCALE_WIDTH'(1) : tx_if.prescale;
                tx_q      <= START_BIT;
                busy_q    <= 1'b1;
                state     <= ST_START;
            end
        end else begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
            if (bit_end) begin
                case (state)
                    ST_START: begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                        tx_q    <= sh_q[0];
                    end
                    ST_DATA: begin
                        if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                            state <= par_en_q ? ST_PARITY : ST_STOP;
                            tx_q  <= par_en_q ? par_bit : STOP_BIT;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            sh_q    <= sh_q >> 1;
                            tx_q    <= sh_q[1];
                        end
                    end
                    ST_PARITY: begin
                        state <= ST_STOP;
                        tx_q  <= STOP_BIT;
                    end
                    ST_STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                        if (!stop_second) begin
                            stop_second <= 1'b1;
                        end else begin
                            stop_second <= 1'b0;
                            state       <= ST_IDLE;
                            busy_q      <= 1'b0;
                        end
`else
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
`endif
                    end
                    default: begin
                        state  <= ST_IDLE;
                        tx_q   <= IDLE_LEVEL;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues hand-computed frames, a monitor checks the line.
// Honours UART_TX_TWO_STOP_EN when computing expected frame lengths.
module tb_uart_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) tx_if ();

    uart_tx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .tx_if (tx_if)
    );

    // bits[i] is the i-th transmitted bit (start bit first)
    typedef struct {
        logic [12:0] bits;
        int          nbits;
        int          pre;
        int          gap;
        bit          abort;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic rst_seen = 1'b1;

    always @(posedge clk) rst_seen <= rst;

    task automatic chk(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic push(input logic [12:0] bits, input int nbits, input int pre,
                        input int gap, input bit abort);
        exp_t e;
        e.bits  = bits;
        e.nbits = nbits;
        e.pre   = (pre == 0) ? 1 : pre;
        e.gap   = gap;
        e.abort = abort;
`ifdef UART_TX_TWO_STOP_EN
        e.bits[nbits] = 1'b1;
        e.nbits       = nbits + 1;
`endif
        sb.push_back(e);
    endtask

    task automatic drive(input logic [7:0] data, input logic par_en, input logic par_typ,
                         input logic [5:0] pre);
        @(posedge clk);
        #1;
        tx_if.P_DATA     = data;
        tx_if.PAR_EN     = par_en;
        tx_if.PAR_TYP    = par_typ;
        tx_if.prescale   = pre;
        tx_if.DATA_VALID = 1'b1;
        @(posedge clk);
        #1;
        tx_if.DATA_VALID = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int limit);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (tx_if.busy !== lvl && k < limit);
        if (tx_if.busy !== lvl) fail("busy_timeout");
    endtask

    // Monitor: idle checks between frames, per-cycle line/busy checks inside a frame
    initial begin
        exp_t cur;
        bit   in_frame = 1'b0;
        int   cyc      = 0;
        int   idle_cnt = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!rst_seen) begin
                chk("reset_tx", tx_if.TX_OUT, 1'b1);
                chk("reset_busy", tx_if.busy, 1'b0);
                if (in_frame && !cur.abort) fail("unexpected_abort");
                in_frame = 1'b0;
                idle_cnt = 0;
            end else begin
                if (!in_frame && tx_if.busy === 1'b1) begin
                    if (sb.size() == 0) begin
                        fail("spurious_frame");
                    end else begin
                        cur      = sb.pop_front();
                        in_frame = 1'b1;
                        cyc      = 0;
                        if (cur.gap >= 0) chk_int("frame_gap", idle_cnt, cur.gap);
                    end
                end
                if (in_frame) begin
                    chk("tx_bit", tx_if.TX_OUT, cur.bits[cyc / cur.pre]);
                    chk("busy_high", tx_if.busy, 1'b1);
                    cyc++;
                    if (cyc == cur.nbits * cur.pre) begin
                        in_frame = 1'b0;
                        idle_cnt = 0;
                        if (cur.abort) fail("abort_not_seen");
                    end
                end else begin
                    chk("idle_tx", tx_if.TX_OUT, 1'b1);
                    chk("idle_busy", tx_if.busy, 1'b0);
                    idle_cnt++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tx_if.P_DATA     = 8'h00;
        tx_if.DATA_VALID = 1'b0;
        tx_if.PAR_EN     = 1'b0;
        tx_if.PAR_TYP    = 1'b0;
        tx_if.prescale   = 6'd8;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (50) @(posedge clk);

        // 0xA5, no parity: 0,1,0,1,0,0,1,0,1,1
        push(13'h034A, 10, 8, -1, 1'b0);
        drive(8'hA5, 1'b0, 1'b0, 6'd8);
        wait_busy(1'b0, 200);

        // 0xA5 even parity -> 0; odd parity -> 1
        push(13'h054A, 11, 8, -1, 1'b0);
        drive(8'hA5, 1'b1, 1'b0, 6'd8);
        wait_busy(1'b0, 200);
        push(13'h074A, 11, 8, -1, 1'b0);
        drive(8'hA5, 1'b1, 1'b1, 6'd8);
        wait_busy(1'b0, 200);

        // Mid-frame request with different settings must be ignored
        push(13'h034A, 10, 8, -1, 1'b0);
        drive(8'hA5, 1'b0, 1'b0, 6'd8);
        repeat (20) @(posedge clk);
        #1;
        tx_if.P_DATA     = 8'hFF;
        tx_if.PAR_EN     = 1'b1;
        tx_if.prescale   = 6'd2;
        tx_if.DATA_VALID = 1'b1;
        @(posedge clk);
        #1 tx_if.DATA_VALID = 1'b0;
        wait_busy(1'b0, 200);
        repeat (30) @(posedge clk);

        // Back-to-back 0x3C at prescale 4: 0,0,0,1,1,1,1,0,0,1 with one idle cycle between
        push(13'h0278, 10, 4, -1, 1'b0);
        push(13'h0278, 10, 4, 1, 1'b0);
        push(13'h0278, 10, 4, 1, 1'b0);
        @(posedge clk);
        #1;
        tx_if.P_DATA     = 8'h3C;
        tx_if.PAR_EN     = 1'b0;
        tx_if.PAR_TYP    = 1'b0;
        tx_if.prescale   = 6'd4;
        tx_if.DATA_VALID = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_busy(1'b1, 20);
            wait_busy(1'b0, 100);
        end
        tx_if.DATA_VALID = 1'b0;
        repeat (5) @(posedge clk);

        // prescale 0 behaves as 1: 0x01 odd parity -> parity 0
        push(13'h0402, 11, 0, -1, 1'b0);
        drive(8'h01, 1'b1, 1'b1, 6'd0);
        wait_busy(1'b0, 50);

        // prescale 1: 0x80 even parity -> parity 1
        push(13'h0700, 11, 1, -1, 1'b0);
        drive(8'h80, 1'b1, 1'b0, 6'd1);
        wait_busy(1'b0, 50);
        repeat (3) @(posedge clk);

        // Reset in the middle of data bit 3 (cycle 36 of the frame)
        push(13'h034A, 10, 8, -1, 1'b1);
        drive(8'hA5, 1'b0, 1'b0, 6'd8);
        repeat (35) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);

        // Next frame after reset goes out intact
        push(13'h074A, 11, 8, -1, 1'b0);
        drive(8'hA5, 1'b1, 1'b1, 6'd8);
        wait_busy(1'b0, 200);
        repeat (5) @(posedge clk);

        if (sb.size() != 0) fail("frames_not_sent");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter; the serializing counterpart of the team's oversampled UART receiver path.
- Accepts a parallel byte plus frame configuration through a valid/busy handshake.
- Drives TX_OUT as: start bit (0), 8 data bits LSB first, optional parity bit, stop bit (1).
- Each bit is held for exactly `prescale` clk cycles, so the receiver, running at the same prescale, samples one bit per prescale window.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- PRESCALE_WIDTH, 6, width of the prescale input; must match the receiver.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- P_DATA  in  DATA_WIDTH  payload byte
- DATA_VALID  in  1  request to send P_DATA; sampled only in IDLE
- PAR_EN  in  1  1 = parity bit inserted (11-bit frame), 0 = no parity (10-bit frame)
- PAR_TYP  in  1  0 = even parity, 1 = odd parity
- prescale  in  PRESCALE_WIDTH  clk cycles per bit; 0 is treated as 1
- TX_OUT  out  1  serial line, registered, idle high
- busy  out  1  high from frame acceptance until the end of the stop bit

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, TX_OUT=1, busy=0; bit counter, cycle counter and shadow registers cleared.
- Reset has priority over all other activity. Reset mid-frame aborts the frame; TX_OUT returns to 1 on that edge, with no partial stop bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, busy=0.
  - On an edge with DATA_VALID=1, latch P_DATA, PAR_EN, PAR_TYP and prescale into shadow registers.
  - Compute parity from the latched data: even = XOR of the bits; odd = inverse of that XOR.
  - On the same edge: TX_OUT<=0, busy<=1, enter START, cycle counter<=0.
  - Input changes after acceptance have no effect on the current frame.
- Cycle counter: increments every clk while not in IDLE. When count == prescale_latched-1, the counter wraps to 0 and the bit advances.
- START: holds 0 for prescale cycles, then enters DATA with TX_OUT<=data[0].
- DATA:
  - Bit index 0..DATA_WIDTH-1; each bit is held prescale cycles.
  - After the last bit: go to PARITY if PAR_EN_latched, else STOP.
- PARITY: drives the latched parity bit for prescale cycles, then enters STOP.
- STOP:
  - Drives 1 for prescale cycles.
  - At the final edge: busy<=0 and state<=IDLE, with TX_OUT staying 1.
- Frame length: 10*prescale cycles (no parity) or 11*prescale cycles (parity). busy is high for exactly that many cycles.
- DATA_VALID while busy=1 is ignored; there is no queueing. The bench must re-present the request after busy falls.
- Back-to-back frames: a DATA_VALID held high is accepted on the first edge with state==IDLE. This guarantees at least 1 idle-high cycle between frames.
- prescale = 0 or 1: each bit lasts 1 cycle.
- Line timing: TX_OUT transitions only at bit boundaries and is glitch-free, since it is a flop output.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN
- Defined:
  - STOP lasts 2*prescale cycles (two stop bits).
  - Frame length becomes 11*prescale (no parity) or 12*prescale (parity).
  - busy timing is extended accordingly.
- Undefined: one stop bit, exactly as specified above.

Decomposition:
- Package uart_pkg:
  - FSM state typedef (IDLE/START/DATA/PARITY/STOP).
  - Frame constants: START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
  - Parity-type encodings PAR_EVEN=0, PAR_ODD=1.
  - Shared with the receiver.
- One natural sub-module: uart_parity_calc.
  - Combinational, DATA_WIDTH data in plus PAR_TYP in, parity bit out.
  - Reusable by the receiver's parity checker.
- Cycle counter and FSM remain in uart_tx.

Test Plan:
- Reset during idle then release; hold DATA_VALID=0 -> TX_OUT=1, busy=0 for 50 cycles.
- prescale=8, PAR_EN=0, P_DATA=0xA5, 1-cycle DATA_VALID -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1, each level held 8 cycles; busy high exactly 80 cycles.
- prescale=8, PAR_EN=1, P_DATA=0xA5:
  - PAR_TYP=0 -> parity bit 0.
  - PAR_TYP=1 -> parity bit 1.
  - busy high 88 cycles.
- During a frame, pulse DATA_VALID with P_DATA=0xFF and change PAR_EN and prescale -> current frame unchanged; no second frame starts.
- DATA_VALID held high with P_DATA=0x3C, prescale=4, PAR_EN=0 -> consecutive frames of 40 cycles, each separated by exactly 1 idle-high cycle.
- Assert rst in the middle of the 4th data bit -> TX_OUT=1 and busy=0 on that edge; the next accepted frame is transmitted correctly from its start bit.
